// File: rtl/floo_txn_dst_tracker_pkg.sv
// Shared types and helpers for the NoRoB destination-ordering tracker.
package floo_txn_dst_tracker_pkg;

  localparam int unsigned DefIdWidth      = 4;
  localparam int unsigned DefDstWidth     = 8;
  localparam int unsigned DefMaxTxnsPerId = 8;

  typedef enum logic [1:0] {
    SlotHold,
    SlotInc,
    SlotDec
  } slot_op_e;

  // Wide enough to hold the value MaxTxnsPerId itself.
  function automatic int unsigned cnt_width(int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

endpackage

// File: rtl/floo_txn_dst_slot.sv
// One tracking slot: outstanding-transaction counter plus last destination.
module floo_txn_dst_slot
  import floo_txn_dst_tracker_pkg::*;
#(
  parameter int unsigned DstWidth = DefDstWidth,
  parameter int unsigned CntWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic [DstWidth-1:0] dst_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic [DstWidth-1:0] dst_o
);

  logic [CntWidth-1:0] r_cnt;
  logic [DstWidth-1:0] r_dst;
  logic [CntWidth-1:0] w_cnt_nxt;
  logic                w_dec_eff;
  slot_op_e            w_op;

  always_comb begin
    // A retire on an empty slot is dropped so the counter never wraps.
    w_dec_eff = dec_i && (r_cnt != '0);
    w_op      = SlotHold;
    if (inc_i && !w_dec_eff) begin
      w_op = SlotInc;
    end else if (!inc_i && w_dec_eff) begin
      w_op = SlotDec;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (w_op)
      SlotInc: w_cnt_nxt = r_cnt + CntWidth'(1);
      SlotDec: w_cnt_nxt = r_cnt - CntWidth'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_dst <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (inc_i) begin
        r_dst <= dst_i;
      end
    end
  end

  assign cnt_o = r_cnt;
  assign dst_o = r_dst;

endmodule

// File: rtl/floo_txn_dst_tracker.sv
// Per-ID ordering guard: stalls requests whose ID is outstanding to another
// destination or whose counter is saturated, so no reorder buffer is needed.
module floo_txn_dst_tracker
  import floo_txn_dst_tracker_pkg::*;
#(
  parameter int unsigned IdWidth      = DefIdWidth,
  parameter int unsigned DstWidth     = DefDstWidth,
  parameter int unsigned MaxTxnsPerId = DefMaxTxnsPerId
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IdWidth-1:0]  req_id_i,
  input  logic [DstWidth-1:0] req_dst_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  logic                rsp_valid_i,
  input  logic                rsp_ready_i,
  input  logic [IdWidth-1:0]  rsp_id_i,
  input  logic                rsp_last_i,
  output logic                busy_o,
  output logic                rsp_err_o
);

  localparam int unsigned NumIds   = 2 ** IdWidth;
  localparam int unsigned CntWidth = cnt_width(MaxTxnsPerId);

  logic [CntWidth-1:0] w_cnt [NumIds];
  logic [DstWidth-1:0] w_dst [NumIds];
  logic [NumIds-1:0]   w_inc;
  logic [NumIds-1:0]   w_dec;
  logic [NumIds-1:0]   w_busy;
  logic [CntWidth-1:0] w_sel_cnt;
  logic                w_stall;
  logic                w_req_hs;
  logic                w_retire;

  assign w_sel_cnt = w_cnt[req_id_i];
  assign w_stall   = (w_sel_cnt != '0) &&
                     ((w_dst[req_id_i] != req_dst_i) ||
                      (w_sel_cnt == CntWidth'(MaxTxnsPerId)));

  // Gated by reset so nothing handshakes while the counters are held clear.
  assign req_valid_o = rst_ni & req_valid_i & ~w_stall;
  assign req_ready_o = rst_ni & req_ready_i & ~w_stall;

  assign w_req_hs  = req_valid_o & req_ready_i;
  assign w_retire  = rst_ni & rsp_valid_i & rsp_ready_i & rsp_last_i;
  assign rsp_err_o = w_retire && (w_cnt[rsp_id_i] == '0);

  always_comb begin
    w_inc           = '0;
    w_dec           = '0;
    w_inc[req_id_i] = w_req_hs;
    w_dec[rsp_id_i] = w_retire;
  end

  for (genvar i = 0; i < NumIds; i++) begin : g_slot
    floo_txn_dst_slot #(
      .DstWidth (DstWidth),
      .CntWidth (CntWidth)
    ) u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (w_inc[i]),
      .dec_i  (w_dec[i]),
      .dst_i  (req_dst_i),
      .cnt_o  (w_cnt[i]),
      .dst_o  (w_dst[i])
    );
    assign w_busy[i] = (w_cnt[i] != '0);
  end

  assign busy_o = |w_busy;

endmodule

// File: tb/tb_floo_txn_dst_tracker.sv
// Directed plus randomized bench against a per-ID outstanding-count model.
module tb_floo_txn_dst_tracker;

  localparam int unsigned IdWidth  = 4;
  localparam int unsigned DstWidth = 8;
  localparam int unsigned MaxTxns  = 8;
  localparam int unsigned NumIds   = 2 ** IdWidth;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                req_valid_i, req_ready_i, req_valid_o, req_ready_o;
  logic [IdWidth-1:0]  req_id_i, rsp_id_i;
  logic [DstWidth-1:0] req_dst_i;
  logic                rsp_valid_i, rsp_ready_i, rsp_last_i;
  logic                busy_o, rsp_err_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: how many transactions are in flight per ID, and where they go.
  int          m_out [NumIds];
  logic [7:0]  m_dst [NumIds];

  always #5 clk_i = ~clk_i;

  floo_txn_dst_tracker #(
    .IdWidth      (IdWidth),
    .DstWidth     (DstWidth),
    .MaxTxnsPerId (MaxTxns)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_id_i    (req_id_i),
    .req_dst_i   (req_dst_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_i    (rsp_id_i),
    .rsp_last_i  (rsp_last_i),
    .busy_o      (busy_o),
    .rsp_err_o   (rsp_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NumIds; i++) begin
      m_out[i] = 0;
      m_dst[i] = '0;
    end
  endtask

  task automatic idle();
    req_valid_i = 1'b0; req_ready_i = 1'b0; req_id_i = '0; req_dst_i = '0;
    rsp_valid_i = 1'b0; rsp_ready_i = 1'b0; rsp_id_i = '0; rsp_last_i = 1'b0;
  endtask

  task automatic set_req(input int id, input int dst);
    req_valid_i = 1'b1; req_ready_i = 1'b1;
    req_id_i = IdWidth'(id); req_dst_i = DstWidth'(dst);
  endtask

  task automatic set_rsp(input int id, input bit last);
    rsp_valid_i = 1'b1; rsp_ready_i = 1'b1;
    rsp_id_i = IdWidth'(id); rsp_last_i = last;
  endtask

  // Inputs are already applied (just after a falling edge); check outputs,
  // advance the model across the rising edge, return on the next falling edge.
  task automatic step(input string tag);
    bit blocked, exp_v, exp_r, hs, ret, exp_err, exp_busy;
    int pre_rsp;
    #1;
    blocked = (m_out[req_id_i] > 0) &&
              ((m_dst[req_id_i] != req_dst_i) || (m_out[req_id_i] >= MaxTxns));
    exp_v   = req_valid_i && !blocked;
    exp_r   = req_ready_i && !blocked;
    hs      = exp_v && req_ready_i;
    ret     = rsp_valid_i && rsp_ready_i && rsp_last_i;
    pre_rsp = m_out[rsp_id_i];
    exp_err = ret && (pre_rsp == 0);
    exp_busy = 1'b0;
    for (int i = 0; i < NumIds; i++) if (m_out[i] > 0) exp_busy = 1'b1;
    chk({tag, ".valid_o"}, 32'(req_valid_o), 32'(exp_v));
    chk({tag, ".ready_o"}, 32'(req_ready_o), 32'(exp_r));
    chk({tag, ".err"},     32'(rsp_err_o),   32'(exp_err));
    chk({tag, ".busy"},    32'(busy_o),      32'(exp_busy));
    if (hs) begin
      m_out[req_id_i]++;
      m_dst[req_id_i] = req_dst_i;
    end
    if (ret && pre_rsp > 0) m_out[rsp_id_i]--;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    idle();
    model_clear();
    rst_ni = 1'b0;
    req_valid_i = 1'b1;
    #2;
    chk("rst.busy",    32'(busy_o),      32'd0);
    chk("rst.valid_o", 32'(req_valid_o), 32'd0);
    idle();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("idle0");

    // Basic pass-through.
    set_req(3, 'h12); step("pass3");
    idle(); step("busy3");

    // Destination mismatch stalls until the outstanding one retires.
    set_req(3, 'h21); step("mis3");
    set_rsp(3, 1'b1); step("mis3_ret");
    idle(); set_req(3, 'h21); step("mis3_go");
    idle(); set_rsp(3, 1'b1); step("clr3");

    // Saturation at MaxTxns, then a 4-beat burst frees one slot.
    for (int i = 0; i < MaxTxns; i++) begin
      idle(); set_req(5, 'h04); step("fill5");
    end
    idle(); set_req(5, 'h04); step("sat5");
    for (int b = 1; b <= 4; b++) begin
      set_rsp(5, b == 4); step("burst5");
    end
    idle(); set_req(5, 'h04); step("sat5_go");

    // Same-ID handshake and retire in one cycle keeps the count.
    idle(); set_req(2, 'h30); step("id2a");
    idle(); set_req(2, 'h30); step("id2b");
    set_rsp(2, 1'b1); step("id2_both");
    idle(); set_req(7, 'h40); step("id7");
    idle(); set_req(2, 'h30); set_rsp(7, 1'b1); step("id2_id7");
    for (int i = 0; i < 4; i++) begin
      idle(); set_rsp(2, 1'b1); step("drain2");
    end
    idle(); set_rsp(7, 1'b1); step("drain7");

    // Retire on an empty ID.
    idle(); set_rsp(9, 1'b1); step("err9");
    idle(); set_rsp(9, 1'b1); set_req(9, 'h55); step("err9_req");
    idle(); set_rsp(9, 1'b1); step("ret9");

    // Async reset with busy slots; old mismatch is accepted afterwards.
    idle(); set_req(11, 'h01); step("b11");
    idle(); set_req(12, 'h02); step("b12");
    idle();
    #2;
    rst_ni = 1'b0;
    #1;
    model_clear();
    req_valid_i = 1'b1; req_ready_i = 1'b1; req_id_i = 4'd5; req_dst_i = 8'h99;
    chk("arst.busy",    32'(busy_o),      32'd0);
    chk("arst.valid_o", 32'(req_valid_o), 32'd0);
    chk("arst.ready_o", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    set_req(5, 'h99); step("post_rst5");
    idle(); set_rsp(11, 1'b1); step("late_rsp11");

    // Randomized traffic concentrated on a few IDs and destinations.
    for (int n = 0; n < 400; n++) begin
      req_valid_i = 1'($urandom_range(0, 1));
      req_ready_i = 1'($urandom_range(0, 3) != 0);
      req_id_i    = IdWidth'($urandom_range(0, 3));
      req_dst_i   = DstWidth'($urandom_range(0, 2));
      rsp_valid_i = 1'($urandom_range(0, 1));
      rsp_ready_i = 1'($urandom_range(0, 3) != 0);
      rsp_id_i    = IdWidth'($urandom_range(0, 3));
      rsp_last_i  = 1'($urandom_range(0, 2) != 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
